bcd_disp_scan: RTL and testbench

//  Reads a bank of cascaded BCD digit counters and drives a time-multiplexed common-anode
//  7-segment display: one digit lit per slot, round-robin, with inter-digit blanking.

---
 rtl/bcd_disp_pkg.sv | 16 +
 rtl/bcd_to_seg7.sv | 17 +
 rtl/bcd_disp_scan.sv | 166 ++++++++++++++++
 tb/tb_bcd_disp_scan.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared types and segment tables for the multiplexed BCD display scanner.
// Pure declarations: no latency, no flow control.
package bcd_disp_pkg;

    typedef enum logic {ST_BLANK = 1'b0, ST_ON = 1'b1} state_t;

    // Segment order {g,f,e,d,c,b,a}, active low
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

endpackage

// File: rtl/bcd_to_seg7.sv
// Nibble to active-low 7-segment pattern; non-decimal nibbles show a dash.
// Combinational, zero latency, no backpressure.
module bcd_to_seg7
    import bcd_disp_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        if (nib <= 4'd9) begin
            seg = SEG_LUT[nib];
        end
    end

endmodule

// File: rtl/bcd_disp_scan.sv
// Round-robin common-anode display scanner with inter-digit blanking; DIGIT_LATCH_EN adds a per-frame input snapshot.
// Outputs registered one clk after the scan decision; enable=0 freezes the scan and darkens the display.
module bcd_disp_scan
    import bcd_disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_pos,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = $clog2(REFRESH_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0] ON_LAST  = DW'(REFRESH_DIV - BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    state_t          state, state_nxt;
    logic [IW-1:0]   idx, idx_nxt;
    logic [DW-1:0]   div, div_nxt;
    logic            started;
    logic            fs_nxt;
    logic            fs_go;

    // The first enabled cycle after reset opens digit 0 without waiting out a slot
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        div_nxt   = div;
        fs_nxt    = 1'b0;
        if (!started) begin
            state_nxt = ST_ON;
            idx_nxt   = '0;
            div_nxt   = '0;
            fs_nxt    = 1'b1;
        end else if (div == DIV_LAST) begin
            state_nxt = ST_ON;
            div_nxt   = '0;
            idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
            fs_nxt    = (idx == IDX_LAST);
        end else begin
            div_nxt = div + 1'b1;
            if (state == ST_ON && div == ON_LAST) begin
                state_nxt = ST_BLANK;
            end
        end
    end

    assign fs_go = enable & fs_nxt;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= ST_BLANK;
            idx     <= '0;
            div     <= '0;
            started <= 1'b0;
        end else if (enable) begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            div     <= div_nxt;
            started <= 1'b1;
        end
    end

    logic [4*NUM_DIGITS-1:0] src_digits;
    logic [NUM_DIGITS-1:0]   src_dp;
    logic                    src_blz;

`ifdef DIGIT_LATCH_EN
    logic [4*NUM_DIGITS-1:0] sh_digits;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic                    sh_blz;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sh_digits <= '0;
            sh_dp     <= '0;
            sh_blz    <= 1'b0;
        end else if (fs_go) begin
            sh_digits <= digits;
            sh_dp     <= dp_pos;
            sh_blz    <= blank_lz;
        end
    end

    // Digit 0 is decoded on the capture edge itself, so it reads the live bus
    assign src_digits = fs_go ? digits   : sh_digits;
    assign src_dp     = fs_go ? dp_pos   : sh_dp;
    assign src_blz    = fs_go ? blank_lz : sh_blz;
`else
    assign src_digits = digits;
    assign src_dp     = dp_pos;
    assign src_blz    = blank_lz;
`endif

    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zero_run;
    logic [3:0]            nib_sel;
    logic                  dp_sel;
    logic                  lz_sel;
    logic [NUM_DIGITS-1:0] an_sel;
    logic [6:0]            seg_dec;
    logic                  lit;

    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run & (src_digits[4*i +: 4] == 4'd0);
            lz_mask[i] = src_blz & zero_run;
        end
    end

    always_comb begin
        nib_sel = '0;
        dp_sel  = 1'b0;
        lz_sel  = 1'b0;
        an_sel  = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_nxt == IW'(i)) begin
                nib_sel   = src_digits[4*i +: 4];
                dp_sel    = src_dp[i];
                lz_sel    = lz_mask[i];
                an_sel[i] = 1'b0;
            end
        end
    end

    bcd_to_seg7 u_dec (
        .nib (nib_sel),
        .seg (seg_dec)
    );

    assign lit = enable & (state_nxt == ST_ON) & ~lz_sel;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            an          <= '1;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= fs_go;
            if (lit) begin
                an  <= an_sel;
                seg <= seg_dec;
                dp  <= ~dp_sel;
            end else begin
                an  <= '1;
                seg <= SEG_OFF;
                dp  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_disp_scan.sv
// Directed bench for bcd_disp_scan with NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1.
module tb_bcd_disp_scan;

    localparam logic [6:0] S0  = 7'b1000000;
    localparam logic [6:0] S1  = 7'b1111001;
    localparam logic [6:0] S2  = 7'b0100100;
    localparam logic [6:0] S3  = 7'b0110000;
    localparam logic [6:0] S4  = 7'b0011001;
    localparam logic [6:0] S7  = 7'b1111000;
    localparam logic [6:0] SD  = 7'b0111111;
    localparam logic [6:0] OFF = 7'h7F;
`ifdef DIGIT_LATCH_EN
    localparam logic [6:0] S_MID = S1;
`else
    localparam logic [6:0] S_MID = S2;
`endif

    logic        clk = 1'b0;
    logic        clr;
    logic        enable;
    logic [15:0] digits;
    logic [3:0]  dp_pos;
    logic        blank_lz;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_disp_scan #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (4),
        .BLANK_CYCLES (1)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .enable      (enable),
        .digits      (digits),
        .dp_pos      (dp_pos),
        .blank_lz    (blank_lz),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_start (frame_start)
    );

    task automatic chk(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e,
                       input logic dp_e, input logic fs_e);
        logic [15:0] obs;
        logic [15:0] exp;
        obs = {3'b000, an, seg, dp, frame_start};
        exp = {3'b000, an_e, seg_e, dp_e, fs_e};
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed{an,seg,dp,fs}=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e,
                        input logic dp_e, input logic fs_e);
        @(negedge clk);
        chk(tag, an_e, seg_e, dp_e, fs_e);
    endtask

    // Three lit cycles (frame_start only on the first) followed by one dark cycle
    task automatic slot(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e,
                        input logic dp_e, input logic fs_e);
        for (int i = 0; i < 3; i++) begin
            step(tag, an_e, seg_e, dp_e, (i == 0) ? fs_e : 1'b0);
        end
        step({tag, "_blank"}, 4'hF, OFF, 1'b1, 1'b0);
    endtask

    initial begin
        clr      = 1'b0;
        enable   = 1'b1;
        digits   = 16'h1234;
        dp_pos   = 4'b0000;
        blank_lz = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset", 4'hF, OFF, 1'b1, 1'b0);
        clr = 1'b1;

        // Live 1234 frame: digit 0 opens immediately with frame_start
        slot("t2_d0", 4'b1110, S4, 1'b1, 1'b1);
        slot("t2_d1", 4'b1101, S3, 1'b1, 1'b0);
        slot("t2_d2", 4'b1011, S2, 1'b1, 1'b0);
        slot("t2_d3", 4'b0111, S1, 1'b1, 1'b0);

        // Async clear in the middle of digit 2's lit period
        slot("t1_d0", 4'b1110, S4, 1'b1, 1'b1);
        slot("t1_d1", 4'b1101, S3, 1'b1, 1'b0);
        step("t1_d2", 4'b1011, S2, 1'b1, 1'b0);
        clr = 1'b0;
        #1;
        chk("t1_clr_now", 4'hF, OFF, 1'b1, 1'b0);
        digits   = 16'h0070;
        blank_lz = 1'b1;
        step("t1_clr_hold", 4'hF, OFF, 1'b1, 1'b0);
        clr = 1'b1;

        // Leading-zero suppression: digits 3 and 2 stay dark, slot timing unchanged
        slot("t3_d0", 4'b1110, S0, 1'b1, 1'b1);
        slot("t3_d1", 4'b1101, S7, 1'b1, 1'b0);
        slot("t3_d2", 4'hF, OFF, 1'b1, 1'b0);
        slot("t3_d3", 4'hF, OFF, 1'b1, 1'b0);

        // Dash for a non-decimal nibble, decimal point on digit 1 only
        digits   = 16'h00A0;
        dp_pos   = 4'b0010;
        blank_lz = 1'b0;
        slot("t4_d0", 4'b1110, S0, 1'b1, 1'b1);
        slot("t4_d1", 4'b1101, SD, 1'b0, 1'b0);
        slot("t4_d2", 4'b1011, S0, 1'b1, 1'b0);
        slot("t4_d3", 4'b0111, S0, 1'b1, 1'b0);

        // Freeze after one lit cycle of digit 2, then resume at the held count
        slot("t5_d0", 4'b1110, S0, 1'b1, 1'b1);
        slot("t5_d1", 4'b1101, SD, 1'b0, 1'b0);
        step("t5_d2_pre", 4'b1011, S0, 1'b1, 1'b0);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step("t5_frozen", 4'hF, OFF, 1'b1, 1'b0);
        end
        enable = 1'b1;
        step("t5_d2_resume1", 4'b1011, S0, 1'b1, 1'b0);
        step("t5_d2_resume2", 4'b1011, S0, 1'b1, 1'b0);
        step("t5_d2_blank", 4'hF, OFF, 1'b1, 1'b0);
        slot("t5_d3", 4'b0111, S0, 1'b1, 1'b0);

        // Counters tick mid-frame: snapshot holds the old value until the next frame
        digits = 16'h1111;
        dp_pos = 4'b0000;
        slot("t6_d0", 4'b1110, S1, 1'b1, 1'b1);
        digits = 16'h2222;
        slot("t6_d1", 4'b1101, S_MID, 1'b1, 1'b0);
        slot("t6_d2", 4'b1011, S_MID, 1'b1, 1'b0);
        slot("t6_d3", 4'b0111, S_MID, 1'b1, 1'b0);
        slot("t6_next_d0", 4'b1110, S2, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
